demux4_reg: RTL
===============

// Module: demux4_reg
// PURPOSE
//  Registered 1-to-4 write-steering demultiplexer; the write-side counterpart of the 4:1 datapath mux.
//  A single 32-bit source word is latched into one of four holding channels selected by controle.
//  Each channel presents its data with a valid/ack handshake to a downstream consumer.
//  Sits between the ALU/memory result path and the four datapath destinations.
// PARAMETERS
//  WIDTH   32   data width of entrada and each saidaN
// PORTS
//  clock     in   1      single system clock; all state updates on rising edge
//  reset     in   1      synchronous, active-high reset
//  entrada   in   WIDTH  source data word
//  controle  in   2      destination select: 00 ch0, 01 ch1, 10 ch2, 11 ch3
//  escrita   in   1      write strobe; entrada captured into channel controle when high
//  pronto    out  1      combinational: selected channel can accept this cycle
//  ack       in   4      per-channel consume strobe from downstream
//  saida0    out  WIDTH  channel 0 held data
//  saida1    out  WIDTH  channel 1 held data
//  saida2    out  WIDTH  channel 2 held data
//  saida3    out  WIDTH  channel 3 held data
//  valido    out  4      per-channel data-valid flags
//  erro      out  1      one-cycle pulse: write refused (overflow)
//  contagem  out  8      accepted-write counter, wraps 255 -> 0
// BEHAVIOUR
//  - Reset (sync, active-high, at rising edge): saida0..3 = 0, valido = 4'b0000, erro = 0, contagem = 0.
//    Reset wins over escrita/ack in the same cycle; mid-operation reset discards all held data.
//  - Per-channel states: VAZIO (valido=0) and CHEIO (valido=1).
//    VAZIO + write to ch       -> CHEIO, saidaN <= entrada.
//    CHEIO + ack[N]            -> VAZIO, saidaN holds last value (not cleared).
//    CHEIO + ack[N] + write    -> CHEIO, saidaN <= new entrada (ack consumes old, write refills).
//    CHEIO + write, no ack[N]  -> CHEIO, data unchanged, write dropped, erro=1 next cycle.
//  - pronto = ~valido[controle] | ack[controle]; independent of escrita.
//  - Latency: write accepted at edge N -> saidaN and valido[N] visible after edge N (1 cycle).
//  - ack[N] while channel VAZIO: ignored, no error.
//  - Only one channel written per cycle; acks on several channels in one cycle all apply.
//  - erro asserts for exactly one cycle per refused write; back-to-back refusals give back-to-back pulses.
//  - contagem increments by 1 per accepted write only (not on refused ones); modulo 256.
//  - escrita low: no channel data changes; controle value irrelevant except for pronto.
//  - No X propagation: all outputs driven from registers or defined logic from reset onward.
// STRUCTURE
//  - Shared package: select codes SEL_ENTRADA0..3 = 2'b00..2'b11, WIDTH default, channel count 4.
//  - Sub-module demux_canal: one holding register + valid flag + refuse detect;
//    inputs clock, reset, we, ack, dado; outputs saida, valido, recusa. Instantiated 4 times.
//  - Top: 2-to-4 one-hot decode of controle gated by escrita, pronto mux, erro register, contagem counter.
// TESTING
//  1. Assert reset 2 cycles -> saida0..3 = 0, valido = 0000, erro = 0, contagem = 0, pronto = 1.
//  2. escrita=1, controle=10, entrada=32'hDEADBEEF one cycle -> saida2 = DEADBEEF, valido = 0100,
//     contagem = 1, other saidaN unchanged; then ack=0100 -> valido = 0000, saida2 still DEADBEEF.
//  3. ch1 CHEIO with 32'h11111111, write 32'h22222222 to ch1 without ack -> pronto=0 before edge,
//     saida1 stays 11111111, erro = 1 for one cycle, contagem unchanged.
//  4. ch3 CHEIO with 32'hAAAA0000, same cycle ack=1000 and write 32'h5555FFFF to ch3 ->
//     valido[3] stays 1, saida3 = 5555FFFF, erro = 0, contagem +1.
//  5. Write all four channels (0x10,0x20,0x30,0x40), then reset asserted during a write of 0x99 ->
//     all saidaN = 0, valido = 0000, contagem = 0; 256 accepted writes from reset -> contagem wraps to 0.
//  6. ack=1111 with valido=0000 and no write -> no state change, erro = 0.

Source files
------------

// File: rtl/demux4_reg_pkg.sv
// demux4_reg shared definitions
// select codes, data width and channel count
package demux4_reg_pkg;

  localparam int WIDTH_PADRAO = 32;
  localparam int NCANAIS      = 4;

  localparam logic [1:0] SEL_ENTRADA0 = 2'b00;
  localparam logic [1:0] SEL_ENTRADA1 = 2'b01;
  localparam logic [1:0] SEL_ENTRADA2 = 2'b10;
  localparam logic [1:0] SEL_ENTRADA3 = 2'b11;

endpackage

// File: rtl/demux4_reg_canal.sv
// demux_canal: one holding channel
// data register, valid flag, refused-write detect
module demux_canal
  import demux4_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_PADRAO
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic             ack,
  input  logic [WIDTH-1:0] dado,
  output logic [WIDTH-1:0] saida,
  output logic             valido,
  output logic             recusa
);

  logic livre;

  // ack in the same cycle frees the slot for a refill
  assign livre  = ~valido | ack;
  assign recusa = we & ~livre;

  // fill on accepted write, drain on ack; data kept after drain
  always_ff @(posedge clock) begin
    if (reset) begin
      saida  <= '0;
      valido <= 1'b0;
    end else if (we && livre) begin
      saida  <= dado;
      valido <= 1'b1;
    end else if (ack) begin
      valido <= 1'b0;
    end
  end

endmodule

// File: rtl/demux4_reg.sv
// demux4_reg: registered 1-to-4 write steering
// four handshaked holding channels with error and count
module demux4_reg
  import demux4_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_PADRAO
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] entrada,
  input  logic [1:0]       controle,
  input  logic             escrita,
  output logic             pronto,
  input  logic [3:0]       ack,
  output logic [WIDTH-1:0] saida0,
  output logic [WIDTH-1:0] saida1,
  output logic [WIDTH-1:0] saida2,
  output logic [WIDTH-1:0] saida3,
  output logic [3:0]       valido,
  output logic             erro,
  output logic [7:0]       contagem
);

  logic [NCANAIS-1:0] we_vec;
  logic [NCANAIS-1:0] recusa;
  logic [WIDTH-1:0]   saida_v [NCANAIS];
  logic               aceita;

  // one-hot write enable for the selected channel
  always_comb begin
    we_vec = '0;
    if (escrita) begin
      unique case (controle)
        SEL_ENTRADA0: we_vec = 4'b0001;
        SEL_ENTRADA1: we_vec = 4'b0010;
        SEL_ENTRADA2: we_vec = 4'b0100;
        SEL_ENTRADA3: we_vec = 4'b1000;
      endcase
    end
  end

  for (genvar i = 0; i < NCANAIS; i++) begin : g_canal
    demux_canal #(.WIDTH(WIDTH)) u_canal (
      .clock  (clock),
      .reset  (reset),
      .we     (we_vec[i]),
      .ack    (ack[i]),
      .dado   (entrada),
      .saida  (saida_v[i]),
      .valido (valido[i]),
      .recusa (recusa[i])
    );
  end

  assign saida0 = saida_v[0];
  assign saida1 = saida_v[1];
  assign saida2 = saida_v[2];
  assign saida3 = saida_v[3];

  assign pronto = ~valido[controle] | ack[controle];
  assign aceita = escrita & pronto;

  // refusal pulse and accepted-write counter
  always_ff @(posedge clock) begin
    if (reset) begin
      erro     <= 1'b0;
      contagem <= '0;
    end else begin
      erro <= |recusa;
      if (aceita) begin
        contagem <= contagem + 8'd1;
      end
    end
  end

endmodule
